data_sram_slave: RTL

DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

---
 rtl/data_sram_slave.sv | 126 ++++++++++++
 1 files changed

// File: rtl/data_sram_slave.sv
// Word-addressed 32-bit data SRAM slave for the memory stage.
// Ports: clk/rst, mem_en/mem_wen/mem_addr/mem_wdata in, mem_rdata/mem_stall/mem_oor out.
module data_sram_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_oor
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READY
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        oor_q;
  logic [31:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] hi_bits;
  logic        oor;
  logic        stall_c;
  logic        perform;
  logic        wr;
  logic        rd;
  logic        unused_lo;

  assign idx       = mem_addr[ADDR_WIDTH+1:2];
  assign hi_bits   = mem_addr >> (ADDR_WIDTH + 2);
  assign oor       = |hi_bits;
  assign unused_lo = ^mem_addr[1:0];

  // IDLE and WAIT stall only while the request is held, so a
  // dropped mem_en (flush) sees no stall in that cycle.
  always_comb begin
    stall_c = 1'b0;
    if (WAIT_CYCLES != 0) begin
      unique case (state_q)
        ST_IDLE:  stall_c = mem_en;
        ST_WAIT:  stall_c = mem_en;
        default:  stall_c = 1'b0;
      endcase
    end
  end

  assign mem_stall = stall_c & rst;
  // rst gating keeps the unreset array from being written in reset.
  assign perform   = mem_en & ~stall_c & rst;
  assign wr        = perform & (|mem_wen) & ~oor;
  assign rd        = perform & ~(|mem_wen);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else if (WAIT_CYCLES == 0) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (mem_en) begin
            if (WAIT_CYCLES == 1) begin
              state_q <= ST_READY;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (!mem_en) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
          end else if (cnt_q == 4'd0) begin
            state_q <= ST_READY;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_READY: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'h0;
      oor_q   <= 1'b0;
    end else begin
      oor_q <= perform & oor;
      if (rd) begin
        rdata_q <= oor ? 32'h0 : mem_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wen[i]) begin
          mem_q[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_oor   = oor_q;

endmodule
